tlb_engine: RTL and testbench
=============================

TLB_ENGINE -- requirements
Module: tlb_engine

Interface
REQ-001 Parameter TLBNUM, default 16, number of TLB entries; index width 4 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  reset is asynchronous and active-high.
REQ-004 s0_vppn/s1_vppn  in  19  search VPN[31:13], port 0 (fetch) and port 1 (data/tlbsrch).
REQ-005 s0_va_bit12/s1_va_bit12  in  1  VA bit 12, selects odd/even page for 4KB pages.
REQ-006 s0_asid/s1_asid  in  10  search ASID per port.
REQ-007 s0_found/s1_found  out  1  hit flag per port.
REQ-008 s0_index/s1_index  out  4  hit entry index per port.
REQ-009 s0_ppn/s1_ppn  out  20, s*_ps out 6, s*_plv out 2, s*_mat out 2, s*_d out 1, s*_v out 1  selected page attributes.
REQ-010 we  in  1  write strobe; w_index in 4; w_e in 1; w_vppn in 19; w_ps in 6; w_asid in 10; w_g in 1.
REQ-011 w_ppn0/w_ppn1 in 20; w_plv0/1 in 2; w_mat0/1 in 2; w_d0/1 in 1; w_v0/1 in 1  even/odd page write data.
REQ-012 r_index  in  4  read index; r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  out  widths as write fields  registered read data.
REQ-013 invtlb_valid  in  1  start INVTLB; invtlb_op in 5; operands taken from s1_asid and s1_vppn.
REQ-014 invtlb_busy  out  1  sweep in progress; invtlb_done  out  1  one-cycle completion pulse; invtlb_err  out  1  valid with done, op illegal.

Function
REQ-015 Search SHALL be combinational: entry i matches when e_i & (g_i | asid_i==s_asid) & VPN compare.
REQ-016 VPN compare: ps_i==12 compares all 19 bits; ps_i==21 compares vppn[18:9] only; any other ps never matches.
REQ-017 Odd page select: ps==12 uses s_va_bit12; ps==21 uses s_vppn[8]; 1 selects page 1 fields.
REQ-018 Multiple hits SHALL report the lowest matching index; no hit drives found=0 and all other search outputs 0.
REQ-019 Write: on rising edge with we=1 and invtlb_busy=0, entry w_index takes all w_* fields; visible to search next cycle.
REQ-020 we while invtlb_busy=1 SHALL be ignored (WB stalls such instructions; not an error).
REQ-021 Read: r_* outputs register entry r_index every cycle, 1-cycle latency; write and read same index same edge returns old data, next cycle new data.
REQ-022 INVTLB FSM states IDLE, SWEEP, DONE; reset state IDLE.
REQ-023 IDLE + invtlb_valid with op<=6: capture op, s1_asid, s1_vppn; go SWEEP with counter=0; invtlb_busy=1 from next cycle.
REQ-024 IDLE + invtlb_valid with op>6: go DONE directly, no entry modified, invtlb_err=1 in DONE.
REQ-025 SWEEP: each cycle evaluate entry[counter], clear its e if predicate true, counter+1; counter==TLBNUM-1 goes DONE (16 sweep cycles, no wrap).
REQ-026 Predicates: op0/op1 all; op2 g=1; op3 g=0; op4 g=0 & asid eq; op5 g=0 & asid eq & VPN compare per REQ-016; op6 (g=1 | asid eq) & VPN compare.
REQ-027 DONE: invtlb_done=1 one cycle, invtlb_busy=0, return IDLE; invtlb_valid in DONE or SWEEP ignored.
REQ-028 Search during SWEEP SHALL reflect entries as already cleared up to the current cycle.
REQ-029 Total INVTLB latency valid-to-done: 18 cycles legal op, 2 cycles illegal op.

Reset
REQ-030 Reset SHALL asynchronously clear all entry e bits and all entry fields to 0, FSM to IDLE, counter to 0.
REQ-031 Reset values: invtlb_busy=0, invtlb_done=0, invtlb_err=0, all r_* = 0; search outputs 0 (no valid entries).
REQ-032 Reset asserted mid-sweep SHALL abort the sweep; no done pulse is produced after release.

Verification
REQ-033 Write idx3 vppn=0x12345 ps=12 asid=5 g=0 ppn0=0xAAAAA ppn1=0xBBBBB e=1; search s1 vppn=0x12345 bit12=1 asid=5 -> found=1 index=3 ppn=0xBBBBB; asid=6 -> found=0.
REQ-034 Write idx2 and idx7 with identical matching 2MB entries (ps=21, g=1) -> search hits index=2; vppn[8]=0 selects ppn0.
REQ-035 Write idx4, same cycle r_index=4 -> r_* old value (0); next cycle r_e=1 and written fields.
REQ-036 Fill 16 entries, even indices g=1; invtlb op=3 -> busy 16 cycles, done pulse at cycle 18, odd entries e=0, even entries e=1; we during busy has no effect.
REQ-037 invtlb op=9 -> done and err high 2 cycles after valid, no entry changed; reset at sweep cycle 5 -> busy=0, no done, all e=0.

Source files
------------

// File: rtl/tlb_engine.sv
// Dual-port searchable TLB with a 1-cycle registered read port and an
// INVTLB sweep engine that visits one entry per cycle.
module tlb_engine #(
  parameter int TLBNUM = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [18:0] i_s0_vppn,
  input  logic        i_s0_va_bit12,
  input  logic [9:0]  i_s0_asid,
  output logic        o_s0_found,
  output logic [3:0]  o_s0_index,
  output logic [19:0] o_s0_ppn,
  output logic [5:0]  o_s0_ps,
  output logic [1:0]  o_s0_plv,
  output logic [1:0]  o_s0_mat,
  output logic        o_s0_d,
  output logic        o_s0_v,
  input  logic [18:0] i_s1_vppn,
  input  logic        i_s1_va_bit12,
  input  logic [9:0]  i_s1_asid,
  output logic        o_s1_found,
  output logic [3:0]  o_s1_index,
  output logic [19:0] o_s1_ppn,
  output logic [5:0]  o_s1_ps,
  output logic [1:0]  o_s1_plv,
  output logic [1:0]  o_s1_mat,
  output logic        o_s1_d,
  output logic        o_s1_v,
  input  logic        i_we,
  input  logic [3:0]  i_w_index,
  input  logic        i_w_e,
  input  logic [18:0] i_w_vppn,
  input  logic [5:0]  i_w_ps,
  input  logic [9:0]  i_w_asid,
  input  logic        i_w_g,
  input  logic [19:0] i_w_ppn0,
  input  logic [19:0] i_w_ppn1,
  input  logic [1:0]  i_w_plv0,
  input  logic [1:0]  i_w_plv1,
  input  logic [1:0]  i_w_mat0,
  input  logic [1:0]  i_w_mat1,
  input  logic        i_w_d0,
  input  logic        i_w_d1,
  input  logic        i_w_v0,
  input  logic        i_w_v1,
  input  logic [3:0]  i_r_index,
  output logic        o_r_e,
  output logic [18:0] o_r_vppn,
  output logic [5:0]  o_r_ps,
  output logic [9:0]  o_r_asid,
  output logic        o_r_g,
  output logic [19:0] o_r_ppn0,
  output logic [19:0] o_r_ppn1,
  output logic [1:0]  o_r_plv0,
  output logic [1:0]  o_r_plv1,
  output logic [1:0]  o_r_mat0,
  output logic [1:0]  o_r_mat1,
  output logic        o_r_d0,
  output logic        o_r_d1,
  output logic        o_r_v0,
  output logic        o_r_v1,
  input  logic        i_invtlb_valid,
  input  logic [4:0]  i_invtlb_op,
  output logic        o_invtlb_busy,
  output logic        o_invtlb_done,
  output logic        o_invtlb_err
);

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [19:0] ppn1;
    logic [1:0]  plv0;
    logic [1:0]  plv1;
    logic [1:0]  mat0;
    logic [1:0]  mat1;
    logic        d0;
    logic        d1;
    logic        v0;
    logic        v1;
  } tlb_ent_t;

  typedef struct packed {
    logic        found;
    logic [3:0]  index;
    logic [19:0] ppn;
    logic [5:0]  ps;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        d;
    logic        v;
  } srch_t;

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  tlb_ent_t    r_tlb [TLBNUM];
  tlb_ent_t    r_rd;
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic        r_bad;
  logic [2:0]  r_inv_op;
  logic [9:0]  r_inv_asid;
  logic [18:0] r_inv_vppn;
  tlb_ent_t    w_wr_ent;
  srch_t       w_s0;
  srch_t       w_s1;

  function automatic logic vpn_hit(input tlb_ent_t t, input logic [18:0] vppn);
    return ((t.ps == 6'd12) && (t.vppn == vppn)) ||
           ((t.ps == 6'd21) && (t.vppn[18:9] == vppn[18:9]));
  endfunction

  // Descending scan so the lowest matching index wins.
  function automatic srch_t lookup(input logic [18:0] vppn,
                                   input logic bit12,
                                   input logic [9:0] asid);
    srch_t r;
    logic  odd;
    r = '0;
    odd = 1'b0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (r_tlb[i].e && (r_tlb[i].g || r_tlb[i].asid == asid) &&
          vpn_hit(r_tlb[i], vppn)) begin
        odd     = (r_tlb[i].ps == 6'd12) ? bit12 : vppn[8];
        r.found = 1'b1;
        r.index = 4'(i);
        r.ps    = r_tlb[i].ps;
        r.ppn   = odd ? r_tlb[i].ppn1 : r_tlb[i].ppn0;
        r.plv   = odd ? r_tlb[i].plv1 : r_tlb[i].plv0;
        r.mat   = odd ? r_tlb[i].mat1 : r_tlb[i].mat0;
        r.d     = odd ? r_tlb[i].d1 : r_tlb[i].d0;
        r.v     = odd ? r_tlb[i].v1 : r_tlb[i].v0;
      end
    end
    return r;
  endfunction

  function automatic logic inv_hit(input tlb_ent_t t);
    logic aeq;
    logic vh;
    aeq = (t.asid == r_inv_asid);
    vh  = vpn_hit(t, r_inv_vppn);
    case (r_inv_op)
      3'd0, 3'd1: return 1'b1;
      3'd2:       return t.g;
      3'd3:       return !t.g;
      3'd4:       return !t.g && aeq;
      3'd5:       return !t.g && aeq && vh;
      3'd6:       return (t.g || aeq) && vh;
      default:    return 1'b0;
    endcase
  endfunction

  assign w_wr_ent = '{
    e: i_w_e, vppn: i_w_vppn, ps: i_w_ps, asid: i_w_asid, g: i_w_g,
    ppn0: i_w_ppn0, ppn1: i_w_ppn1, plv0: i_w_plv0, plv1: i_w_plv1,
    mat0: i_w_mat0, mat1: i_w_mat1, d0: i_w_d0, d1: i_w_d1,
    v0: i_w_v0, v1: i_w_v1
  };

  assign w_s0 = lookup(i_s0_vppn, i_s0_va_bit12, i_s0_asid);
  assign w_s1 = lookup(i_s1_vppn, i_s1_va_bit12, i_s1_asid);

  // Sweep owns the array while busy, so stalled writes are simply dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < TLBNUM; i++) r_tlb[i] <= '0;
    end else if (r_state == S_SWEEP) begin
      if (inv_hit(r_tlb[r_cnt])) r_tlb[r_cnt].e <= 1'b0;
    end else if (i_we) begin
      r_tlb[i_w_index] <= w_wr_ent;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd <= '0;
    else       r_rd <= r_tlb[i_r_index];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_bad      <= 1'b0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_vppn <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_invtlb_valid) begin
            if (i_invtlb_op <= 5'd6) begin
              r_inv_op   <= i_invtlb_op[2:0];
              r_inv_asid <= i_s1_asid;
              r_inv_vppn <= i_s1_vppn;
              r_cnt      <= '0;
              r_busy     <= 1'b1;
              r_bad      <= 1'b0;
              r_state    <= S_SWEEP;
            end else begin
              r_bad   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_SWEEP: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'(TLBNUM - 1)) begin
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_err   <= r_bad;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_s0_found = w_s0.found;
  assign o_s0_index = w_s0.index;
  assign o_s0_ppn   = w_s0.ppn;
  assign o_s0_ps    = w_s0.ps;
  assign o_s0_plv   = w_s0.plv;
  assign o_s0_mat   = w_s0.mat;
  assign o_s0_d     = w_s0.d;
  assign o_s0_v     = w_s0.v;
  assign o_s1_found = w_s1.found;
  assign o_s1_index = w_s1.index;
  assign o_s1_ppn   = w_s1.ppn;
  assign o_s1_ps    = w_s1.ps;
  assign o_s1_plv   = w_s1.plv;
  assign o_s1_mat   = w_s1.mat;
  assign o_s1_d     = w_s1.d;
  assign o_s1_v     = w_s1.v;

  assign o_r_e    = r_rd.e;
  assign o_r_vppn = r_rd.vppn;
  assign o_r_ps   = r_rd.ps;
  assign o_r_asid = r_rd.asid;
  assign o_r_g    = r_rd.g;
  assign o_r_ppn0 = r_rd.ppn0;
  assign o_r_ppn1 = r_rd.ppn1;
  assign o_r_plv0 = r_rd.plv0;
  assign o_r_plv1 = r_rd.plv1;
  assign o_r_mat0 = r_rd.mat0;
  assign o_r_mat1 = r_rd.mat1;
  assign o_r_d0   = r_rd.d0;
  assign o_r_d1   = r_rd.d1;
  assign o_r_v0   = r_rd.v0;
  assign o_r_v1   = r_rd.v1;

  assign o_invtlb_busy = r_busy;
  assign o_invtlb_done = r_done;
  assign o_invtlb_err  = r_err;

endmodule

// File: tb/tb_tlb_engine.sv
// Directed and randomized bench for tlb_engine against an array-based
// reference model of the TLB contents and INVTLB rules.
module tb_tlb_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [18:0] s0_vppn, s1_vppn;
  logic        s0_b12, s1_b12;
  logic [9:0]  s0_asid, s1_asid;
  logic        s0_found, s1_found;
  logic [3:0]  s0_index, s1_index;
  logic [19:0] s0_ppn, s1_ppn;
  logic [5:0]  s0_ps, s1_ps;
  logic [1:0]  s0_plv, s1_plv, s0_mat, s1_mat;
  logic        s0_d, s1_d, s0_v, s1_v;
  logic        we, w_e, w_g, w_d0, w_d1, w_v0, w_v1;
  logic [3:0]  w_index, r_index;
  logic [18:0] w_vppn;
  logic [5:0]  w_ps;
  logic [9:0]  w_asid;
  logic [19:0] w_ppn0, w_ppn1;
  logic [1:0]  w_plv0, w_plv1, w_mat0, w_mat1;
  logic        r_e, r_g, r_d0, r_d1, r_v0, r_v1;
  logic [18:0] r_vppn;
  logic [5:0]  r_ps;
  logic [9:0]  r_asid;
  logic [19:0] r_ppn0, r_ppn1;
  logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;
  logic        inv_valid, busy, done, err;
  logic [4:0]  inv_op;

  tlb_engine dut (
    .i_clk(clk), .i_rst(rst),
    .i_s0_vppn(s0_vppn), .i_s0_va_bit12(s0_b12), .i_s0_asid(s0_asid),
    .o_s0_found(s0_found), .o_s0_index(s0_index), .o_s0_ppn(s0_ppn),
    .o_s0_ps(s0_ps), .o_s0_plv(s0_plv), .o_s0_mat(s0_mat),
    .o_s0_d(s0_d), .o_s0_v(s0_v),
    .i_s1_vppn(s1_vppn), .i_s1_va_bit12(s1_b12), .i_s1_asid(s1_asid),
    .o_s1_found(s1_found), .o_s1_index(s1_index), .o_s1_ppn(s1_ppn),
    .o_s1_ps(s1_ps), .o_s1_plv(s1_plv), .o_s1_mat(s1_mat),
    .o_s1_d(s1_d), .o_s1_v(s1_v),
    .i_we(we), .i_w_index(w_index), .i_w_e(w_e), .i_w_vppn(w_vppn),
    .i_w_ps(w_ps), .i_w_asid(w_asid), .i_w_g(w_g),
    .i_w_ppn0(w_ppn0), .i_w_ppn1(w_ppn1), .i_w_plv0(w_plv0),
    .i_w_plv1(w_plv1), .i_w_mat0(w_mat0), .i_w_mat1(w_mat1),
    .i_w_d0(w_d0), .i_w_d1(w_d1), .i_w_v0(w_v0), .i_w_v1(w_v1),
    .i_r_index(r_index), .o_r_e(r_e), .o_r_vppn(r_vppn), .o_r_ps(r_ps),
    .o_r_asid(r_asid), .o_r_g(r_g), .o_r_ppn0(r_ppn0), .o_r_ppn1(r_ppn1),
    .o_r_plv0(r_plv0), .o_r_plv1(r_plv1), .o_r_mat0(r_mat0),
    .o_r_mat1(r_mat1), .o_r_d0(r_d0), .o_r_d1(r_d1),
    .o_r_v0(r_v0), .o_r_v1(r_v1),
    .i_invtlb_valid(inv_valid), .i_invtlb_op(inv_op),
    .o_invtlb_busy(busy), .o_invtlb_done(done), .o_invtlb_err(err)
  );

  typedef struct {
    bit        e;
    bit [18:0] vppn;
    bit [5:0]  ps;
    bit [9:0]  asid;
    bit        g;
    bit [19:0] ppn [2];
    bit [1:0]  plv [2];
    bit [1:0]  mat [2];
    bit        d [2];
    bit        v [2];
  } ment_t;

  ment_t m [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic ment_t zent();
    ment_t t;
    t.e = 0; t.vppn = 0; t.ps = 0; t.asid = 0; t.g = 0;
    for (int k = 0; k < 2; k++) begin
      t.ppn[k] = 0; t.plv[k] = 0; t.mat[k] = 0; t.d[k] = 0; t.v[k] = 0;
    end
    return t;
  endfunction

  function automatic ment_t rent();
    ment_t t;
    int    r;
    t = zent();
    r = $urandom % 8;
    t.e = ($urandom % 4) != 0;
    t.vppn = 19'($urandom);
    t.ps = (r < 4) ? 6'd12 : (r < 7) ? 6'd21 : 6'd13;
    t.asid = 10'($urandom % 4);
    t.g = ($urandom % 3) == 0;
    for (int k = 0; k < 2; k++) begin
      t.ppn[k] = 20'($urandom); t.plv[k] = 2'($urandom);
      t.mat[k] = 2'($urandom); t.d[k] = 1'($urandom);
      t.v[k] = 1'($urandom);
    end
    return t;
  endfunction

  function automatic bit vmatch(input ment_t t, input logic [18:0] vp);
    if (t.ps == 12) return t.vppn == vp;
    if (t.ps == 21) return (t.vppn >> 9) == (vp >> 9);
    return 0;
  endfunction

  function automatic int mfind(input logic [18:0] vp, input logic [9:0] as);
    for (int i = 0; i < 16; i++)
      if (m[i].e && (m[i].g || m[i].asid == as) && vmatch(m[i], vp))
        return i;
    return -1;
  endfunction

  function automatic bit mpred(input int op, input logic [9:0] as,
                               input logic [18:0] vp, input ment_t t);
    bit aeq;
    aeq = (t.asid == as);
    if (op <= 1) return 1;
    if (op == 2) return t.g;
    if (op == 3) return !t.g;
    if (op == 4) return !t.g && aeq;
    if (op == 5) return !t.g && aeq && vmatch(t, vp);
    return (t.g || aeq) && vmatch(t, vp);
  endfunction

  task automatic srch(input bit port, input logic [18:0] vp, input logic b,
                      input logic [9:0] as, input string tag);
    int k;
    int o;
    logic [31:0] ef, ei, ep, ea, of_, oi, op_, oa;
    if (!port) begin s0_vppn = vp; s0_b12 = b; s0_asid = as; end
    else       begin s1_vppn = vp; s1_b12 = b; s1_asid = as; end
    #1;
    k = mfind(vp, as);
    ef = 0; ei = 0; ep = 0; ea = 0;
    if (k >= 0) begin
      o  = (m[k].ps == 12) ? int'(b) : int'(vp[8]);
      ef = 1;
      ei = 32'(k);
      ep = 32'(m[k].ppn[o]);
      ea = 32'({m[k].ps, m[k].plv[o], m[k].mat[o], m[k].d[o], m[k].v[o]});
    end
    if (!port) begin
      of_ = 32'(s0_found); oi = 32'(s0_index); op_ = 32'(s0_ppn);
      oa = 32'({s0_ps, s0_plv, s0_mat, s0_d, s0_v});
    end else begin
      of_ = 32'(s1_found); oi = 32'(s1_index); op_ = 32'(s1_ppn);
      oa = 32'({s1_ps, s1_plv, s1_mat, s1_d, s1_v});
    end
    chk({tag, ".found"}, of_, ef);
    chk({tag, ".index"}, oi, ei);
    chk({tag, ".ppn"}, op_, ep);
    chk({tag, ".attr"}, oa, ea);
  endtask

  task automatic rd(input int idx, input string tag);
    ment_t t;
    r_index = 4'(idx);
    tick();
    t = m[idx];
    chk({tag, ".e"}, 32'(r_e), 32'(t.e));
    chk({tag, ".vppn"}, 32'(r_vppn), 32'(t.vppn));
    chk({tag, ".ppn0"}, 32'(r_ppn0), 32'(t.ppn[0]));
    chk({tag, ".ppn1"}, 32'(r_ppn1), 32'(t.ppn[1]));
    chk({tag, ".misc"},
        32'({r_ps, r_asid, r_g, r_plv0, r_plv1, r_mat0, r_mat1,
             r_d0, r_d1, r_v0, r_v1}),
        32'({t.ps, t.asid, t.g, t.plv[0], t.plv[1], t.mat[0], t.mat[1],
             t.d[0], t.d[1], t.v[0], t.v[1]}));
  endtask

  task automatic wr(input int idx, input ment_t t);
    w_index = 4'(idx); w_e = t.e; w_vppn = t.vppn; w_ps = t.ps;
    w_asid = t.asid; w_g = t.g;
    w_ppn0 = t.ppn[0]; w_ppn1 = t.ppn[1];
    w_plv0 = t.plv[0]; w_plv1 = t.plv[1];
    w_mat0 = t.mat[0]; w_mat1 = t.mat[1];
    w_d0 = t.d[0]; w_d1 = t.d[1]; w_v0 = t.v[0]; w_v1 = t.v[1];
    we = 1;
    tick();
    we = 0;
    m[idx] = t;
  endtask

  // Valid in cycle 0; entry c-2 has been swept by cycle c; busy in
  // cycles 1..16 and the done pulse in cycle 18.
  task automatic run_inv(input int op, input logic [9:0] as,
                         input logic [18:0] vp, input string tag);
    s1_asid = as; s1_vppn = vp; inv_op = 5'(op); inv_valid = 1;
    tick();
    inv_valid = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c >= 2 && c <= 17 && mpred(op, as, vp, m[c-2])) m[c-2].e = 0;
      if (c == 3) begin inv_valid = 1; inv_op = 5'd0; end
      if (c == 4) inv_valid = 0;
      if (c == 5) begin
        we = 1; w_index = 4'd1; w_e = 1; w_g = 1; w_ps = 6'd12;
      end
      if (c == 6) we = 0;
      chk({tag, ".busy"}, 32'(busy), 32'(c <= 16));
      chk({tag, ".done"}, 32'(done), 32'(c == 18));
      if (c == 18) chk({tag, ".err"}, 32'(err), 0);
      srch(0, m[c % 16].vppn, 1'b0, m[c % 16].asid, {tag, ".s0"});
      tick();
    end
  endtask

  initial begin
    ment_t t;
    int    j;
    logic [18:0] vp;
    logic [9:0]  as;
    rst = 1;
    {s0_vppn, s1_vppn, s0_b12, s1_b12, s0_asid, s1_asid} = '0;
    {we, w_e, w_g, w_d0, w_d1, w_v0, w_v1, w_index, r_index} = '0;
    {w_vppn, w_ps, w_asid, w_ppn0, w_ppn1} = '0;
    {w_plv0, w_plv1, w_mat0, w_mat1, inv_valid, inv_op} = '0;
    for (int i = 0; i < 16; i++) m[i] = zent();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.r_e", 32'(r_e), 0);
    chk("rst.r_ppn0", 32'(r_ppn0), 0);
    srch(0, 19'h0, 1'b0, 10'h0, "rst.s0");
    srch(1, 19'h0, 1'b1, 10'h0, "rst.s1");

    t = zent();
    t.e = 1; t.vppn = 19'h12345; t.ps = 12; t.asid = 5;
    t.ppn[0] = 20'hAAAAA; t.ppn[1] = 20'hBBBBB;
    wr(3, t);
    srch(1, 19'h12345, 1'b1, 10'd5, "basic.hit");
    chk("basic.idx", 32'(s1_index), 3);
    chk("basic.ppn", 32'(s1_ppn), 32'h000BBBBB);
    srch(1, 19'h12345, 1'b1, 10'd6, "basic.asid");
    chk("basic.miss", 32'(s1_found), 0);

    t = zent();
    t.e = 1; t.vppn = 19'h2A000; t.ps = 21; t.g = 1; t.asid = 9;
    t.ppn[0] = 20'h11111; t.ppn[1] = 20'h22222;
    wr(2, t);
    wr(7, t);
    srch(1, 19'h2A0FF, 1'b1, 10'd3, "huge");
    chk("huge.idx", 32'(s1_index), 2);
    chk("huge.ppn", 32'(s1_ppn), 32'h00011111);

    t = rent();
    t.e = 1;
    r_index = 4'd4;
    wr(4, t);
    chk("rdw.old_e", 32'(r_e), 0);
    chk("rdw.old_ppn", 32'(r_ppn0), 0);
    tick();
    chk("rdw.new_e", 32'(r_e), 1);
    chk("rdw.new_ppn", 32'(r_ppn0), 32'(t.ppn[0]));

    for (int n = 0; n < 40; n++) wr($urandom % 16, rent());
    for (int n = 0; n < 100; n++) begin
      for (int p = 0; p < 2; p++) begin
        j = $urandom % 16;
        vp = m[j].vppn;
        case ($urandom % 3)
          0: ;
          1: vp = vp ^ 19'($urandom % 512);
          default: vp = 19'($urandom);
        endcase
        as = ($urandom % 2) ? m[j].asid : 10'($urandom % 4);
        srch(p[0], vp, 1'($urandom), as, "rnd");
      end
      rd($urandom % 16, "rnd.rd");
    end

    for (int i = 0; i < 16; i++) begin
      t = rent();
      t.e = 1; t.ps = 12; t.vppn = 19'(i * 37 + 5);
      t.asid = 10'(i); t.g = (i % 2) == 0;
      wr(i, t);
    end
    run_inv(3, 10'd0, 19'd0, "inv3");
    for (int i = 0; i < 16; i++) begin
      rd(i, "inv3.rd");
      chk("inv3.eparity", 32'(r_e), 32'((i % 2) == 0));
    end

    s1_asid = 0; s1_vppn = 0; inv_op = 5'd9; inv_valid = 1;
    tick();
    inv_valid = 0;
    chk("ill.done1", 32'(done), 0);
    chk("ill.busy1", 32'(busy), 0);
    tick();
    chk("ill.done2", 32'(done), 1);
    chk("ill.err2", 32'(err), 1);
    tick();
    chk("ill.done3", 32'(done), 0);
    for (int i = 0; i < 16; i++) rd(i, "ill.rd");

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) wr(i, rent());
      j = $urandom % 16;
      vp = m[j].vppn ^ 19'(($urandom % 2) * ($urandom % 512));
      run_inv($urandom % 7, m[j].asid, vp, "invr");
      for (int i = 0; i < 16; i++) rd(i, "invr.rd");
    end

    for (int i = 0; i < 16; i++) wr(i, rent());
    s1_asid = 0; s1_vppn = 0; inv_op = 5'd2; inv_valid = 1;
    tick();
    inv_valid = 0;
    repeat (4) tick();
    chk("abort.busy_pre", 32'(busy), 1);
    rst = 1;
    #1;
    chk("abort.busy", 32'(busy), 0);
    chk("abort.r_e", 32'(r_e), 0);
    for (int i = 0; i < 16; i++) m[i] = zent();
    #2 rst = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      chk("abort.nodone", 32'(done), 0);
      chk("abort.nobusy", 32'(busy), 0);
    end
    for (int i = 0; i < 16; i++) rd(i, "abort.rd");
    srch(0, 19'h12345, 1'b0, 10'd0, "abort.s0");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
